// File: rtl/act_pkg.sv
// Shared definitions for the forward activation and gradient paths: function codes,
// Q8.8 breakpoints and derivative slopes.
package act_pkg;

  typedef enum logic [1:0] {
    FUNC_LINEAR  = 2'b00,
    FUNC_RELU    = 2'b01,
    FUNC_SIGMOID = 2'b10,
    FUNC_TANH    = 2'b11
  } func_e;

  localparam int SLOPE_W = 9;
  localparam int PROD_W  = 25;

  localparam logic signed [15:0] ONE      = 16'sd256;
  localparam logic signed [15:0] BP_P256  = 16'sd256;
  localparam logic signed [15:0] BP_N256  = -16'sd256;
  localparam logic signed [15:0] BP_P512  = 16'sd512;
  localparam logic signed [15:0] BP_N512  = -16'sd512;
  localparam logic signed [15:0] BP_P1024 = 16'sd1024;
  localparam logic signed [15:0] BP_N1024 = -16'sd1024;
  localparam logic signed [15:0] BP_P2048 = 16'sd2048;
  localparam logic signed [15:0] BP_N2048 = -16'sd2048;

  localparam logic [SLOPE_W-1:0] SLOPE_0   = 9'd0;
  localparam logic [SLOPE_W-1:0] SLOPE_16  = 9'd16;
  localparam logic [SLOPE_W-1:0] SLOPE_64  = 9'd64;
  localparam logic [SLOPE_W-1:0] SLOPE_256 = 9'd256;

  // Lower bound inclusive, upper bound exclusive.
  function automatic logic in_range(input logic signed [15:0] x,
                                    input logic signed [15:0] lo,
                                    input logic signed [15:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/act_slope_lut.sv
// Combinational derivative lookup: maps (function code, x) to the unsigned Q8.8 slope.
module act_slope_lut
  import act_pkg::*;
(
  input  func_e               i_func,
  input  logic signed [15:0]  i_x,
  output logic [SLOPE_W-1:0]  o_slope
);

  // Piecewise-constant derivative of each forward approximation.
  always_comb begin
    o_slope = SLOPE_0;
    case (i_func)
      FUNC_LINEAR: o_slope = SLOPE_256;
      FUNC_RELU: begin
        if (i_x[15]) o_slope = SLOPE_0;
        else         o_slope = SLOPE_256;
      end
      FUNC_SIGMOID: begin
        if (in_range(i_x, BP_N512, BP_P512))        o_slope = SLOPE_64;
        else if (in_range(i_x, BP_N2048, BP_P2048)) o_slope = SLOPE_16;
        else                                        o_slope = SLOPE_0;
      end
      FUNC_TANH: begin
        if (in_range(i_x, BP_N256, BP_P256))        o_slope = SLOPE_256;
        else if (in_range(i_x, BP_N1024, BP_P1024)) o_slope = SLOPE_64;
        else                                        o_slope = SLOPE_0;
      end
      default: o_slope = SLOPE_0;
    endcase
  end

endmodule

// File: rtl/activation_grad_unit.sv
// Two-stage streaming gradient unit: dx = (dy * f'(x)) >>> FRAC_W.
// Optional dead-neuron counter enabled by defining ACT_GRAD_ZERO_COUNT_EN.
module activation_grad_unit
  import act_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_func,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_dy,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_dx,
  output logic              out_last
`ifdef ACT_GRAD_ZERO_COUNT_EN
  ,
  output logic [15:0]       zero_count,
  input  logic              zero_count_clr
`endif
);

  logic [SLOPE_W-1:0]       w_slope;
  logic                     w_en;
  logic                     w_accept;
  logic signed [PROD_W-1:0] w_prod;

  logic                     r_s1_valid;
  logic [SLOPE_W-1:0]       r_s1_slope;
  logic [DATA_W-1:0]        r_s1_dy;
  logic                     r_s1_last;
  logic                     r_s1_zero;
  logic                     r_s2_valid;
  logic [DATA_W-1:0]        r_dx;
  logic                     r_last;

  act_slope_lut u_lut (
    .i_func  (func_e'(in_func)),
    .i_x     (in_x),
    .o_slope (w_slope)
  );

  // A full S2 that is not being drained freezes the whole pipe, bubbles included.
  assign w_en     = !r_s2_valid || out_ready;
  assign in_ready = w_en;
  assign w_accept = in_valid && w_en;

  // Product width leaves headroom so -32768 * 256 stays representable.
  assign w_prod = $signed({{(PROD_W-DATA_W){r_s1_dy[DATA_W-1]}}, r_s1_dy})
                * $signed({{(PROD_W-SLOPE_W){1'b0}}, r_s1_slope});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_slope <= SLOPE_0;
      r_s1_dy    <= '0;
      r_s1_last  <= 1'b0;
      r_s1_zero  <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_slope <= w_slope;
        r_s1_dy    <= in_dy;
        r_s1_last  <= in_last;
        r_s1_zero  <= (w_slope == SLOPE_0);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_dx       <= '0;
      r_last     <= 1'b0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_dx   <= r_s1_zero ? {DATA_W{1'b0}} : DATA_W'(w_prod >>> FRAC_W);
        r_last <= r_s1_last;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_dx    = r_dx;
  assign out_last  = r_last;

`ifdef ACT_GRAD_ZERO_COUNT_EN
  logic [15:0] r_zero_count;

  // Clear wins over a same-cycle increment; count saturates at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_zero_count <= 16'd0;
    end else if (zero_count_clr) begin
      r_zero_count <= 16'd0;
    end else if (w_accept && (w_slope == SLOPE_0) && (r_zero_count != 16'hFFFF)) begin
      r_zero_count <= r_zero_count + 16'd1;
    end
  end

  assign zero_count = r_zero_count;
`endif

endmodule

// File: tb/tb_activation_grad_unit.sv
// Self-checking bench for activation_grad_unit: scoreboard against an arithmetic
// reference model, directed boundary sweeps, backpressure, reset and random traffic.
module tb_activation_grad_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_func = 2'd0;
  logic [15:0] in_x = 16'd0;
  logic [15:0] in_dy = 16'd0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_dx;
  logic        out_last;
`ifdef ACT_GRAD_ZERO_COUNT_EN
  logic [15:0] zero_count;
  logic        zero_count_clr = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int exp_dx_q[$];
  bit exp_last_q[$];
  bit rand_done;

  activation_grad_unit #(.DATA_W(16), .FRAC_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_func   (in_func),
    .in_x      (in_x),
    .in_dy     (in_dy),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dx    (out_dx),
    .out_last  (out_last)
`ifdef ACT_GRAD_ZERO_COUNT_EN
    ,
    .zero_count     (zero_count),
    .zero_count_clr (zero_count_clr)
`endif
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Derivative of the forward approximations, straight from the breakpoint tables.
  function automatic int ref_slope(input int f, input int x);
    case (f)
      0: return 256;
      1: return (x < 0) ? 0 : 256;
      2: begin
        if (x < -2048 || x >= 2048) return 0;
        else if (x < -512 || x >= 512) return 16;
        else return 64;
      end
      3: begin
        if (x < -1024 || x >= 1024) return 0;
        else if (x < -256 || x >= 256) return 64;
        else return 256;
      end
      default: return 0;
    endcase
  endfunction

  // Scoreboard: inputs are stable mid-cycle, so handshakes seen here happen at the next edge.
  always @(negedge clock) begin
    if (reset) begin
      exp_dx_q.delete();
      exp_last_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_dx_q.size() == 0) begin
          check_eq("spurious_out", 1, 0);
        end else begin
          check_eq("dx", $signed(out_dx), exp_dx_q[0]);
          check_eq("last", int'(out_last), int'(exp_last_q[0]));
          if (out_ready) begin
            void'(exp_dx_q.pop_front());
            void'(exp_last_q.pop_front());
          end
        end
        if (!out_ready) check_eq("in_ready_bp", int'(in_ready), 0);
      end
      if (in_valid && in_ready) begin
        exp_dx_q.push_back((int'($signed(in_dy)) * ref_slope(int'(in_func), int'($signed(in_x)))) >>> 8);
        exp_last_q.push_back(in_last);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send(input int f, input int x, input int dy, input bit last);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_func  = 2'(f);
    in_x     = 16'(x);
    in_dy    = 16'(dy);
    in_last  = last;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clock);
      if (in_ready) done = 1'b1;
      @(posedge clock);
      #1;
    end
    if (!done) check_eq("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_dx_q.size() != 0; k++) idle(1);
    check_eq("drain_empty", exp_dx_q.size(), 0);
    idle(2);
  endtask

  int sig_x[9]  = '{-2049, -2048, -513, -512, 0, 511, 512, 2047, 2048};
  int tanh_x[7] = '{-1025, -1024, -257, -256, 255, 256, 1024};

  initial begin
    #2;
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_out_dx", int'(out_dx), 0);
    check_eq("rst_out_last", int'(out_last), 0);
    check_eq("rst_in_ready", int'(in_ready), 1);
`ifdef ACT_GRAD_ZERO_COUNT_EN
    check_eq("rst_zero_count", int'(zero_count), 0);
`endif
    idle(3);
    reset = 1'b0;
    idle(1);

    foreach (sig_x[i]) send(2, sig_x[i], 256, 1'b0);
    foreach (tanh_x[i]) send(3, tanh_x[i], 256, 1'b0);
    send(1, -1, 256, 1'b0);
    send(1, 0, 256, 1'b0);
    send(2, 0, -3, 1'b0);
    send(0, 0, -32768, 1'b0);
    send(3, 300, 100, 1'b1);
    drain();

    // Backpressure: 10 beats with gaps while out_ready drops for 5 cycles.
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(int'($urandom_range(0, 3)), int'($urandom_range(0, 8191)) - 4096,
               int'($urandom_range(0, 65535)) - 32768, i == 9);
          idle(int'($urandom_range(0, 2)));
        end
      end
      begin
        idle(3);
        out_ready = 1'b0;
        idle(5);
        out_ready = 1'b1;
      end
    join
    drain();

    // Full rate: out_valid expected for 16 consecutive cycles starting 2 after the first.
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 16);
      in_func  = 2'd3;
      in_x     = 16'(c * 40 - 300);
      in_dy    = 16'(c * 97 + 5);
      in_last  = (c == 15);
      @(negedge clock);
      check_eq("fullrate_valid", int'(out_valid), int'(c >= 2 && c < 18));
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain();

    // Random mixed traffic under random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 65535)) - 32768, $urandom_range(0, 7) == 0);
          idle(int'($urandom_range(0, 1)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          idle(1);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset mid-stream with beats in flight.
    in_valid = 1'b1;
    in_func  = 2'd0;
    in_x     = 16'd0;
    in_dy    = 16'd77;
    idle(2);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_eq("midrst_out_valid", int'(out_valid), 0);
    check_eq("midrst_out_dx", int'(out_dx), 0);
    check_eq("midrst_in_ready", int'(in_ready), 1);
    in_valid = 1'b0;
    idle(2);
    reset = 1'b0;
    send(0, 0, 555, 1'b1);
    drain();

`ifdef ACT_GRAD_ZERO_COUNT_EN
    zero_count_clr = 1'b1;
    idle(1);
    zero_count_clr = 1'b0;
    for (int i = 0; i < 5; i++) send(2, 3000, 100, 1'b0);
    idle(1);
    check_eq("zc_five", int'(zero_count), 5);
    zero_count_clr = 1'b1;
    send(2, 3000, 100, 1'b0);
    zero_count_clr = 1'b0;
    check_eq("zc_clr_wins", int'(zero_count), 0);
    drain();
    in_valid = 1'b1;
    in_func  = 2'd2;
    in_x     = 16'd3000;
    in_dy    = 16'd1;
    idle(70000);
    in_valid = 1'b0;
    idle(1);
    check_eq("zc_saturate", int'(zero_count), 65535);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
